// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: A/B/Z outputs and position modulo CPR, with a programmable step rate.
// Latency: a step fires on the edge where div_cnt >= period; the new A/B/Z/position/step_pulse appear after that edge.
// Backpressure: none. en low freezes the prescaler and state. An invalid request (neither or both directions) clears the prescaler.
// Optional: define ENC_POS_LOAD_EN to add the pos_load/pos_value synchronous position preset.
module quad_encoder_gen #(
  parameter int CPR   = 400,  // multiple of 4, >= 4
  parameter int DIV_W = 16,
  parameter int POS_W = 16    // 2**POS_W >= CPR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             horario,
  input  logic             antihorario,
  input  logic [DIV_W-1:0] period,
`ifdef ENC_POS_LOAD_EN
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_value,
`endif
  output logic             A,
  output logic             B,
  output logic             Z,
  output logic [POS_W-1:0] position,
  output logic             dir,
  output logic             step_pulse
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);

  // The quadrature phase is a pure function of position mod 4.
  // This holds across the wrap because CPR is a multiple of 4.
  function automatic logic [1:0] phase_of(input logic [1:0] p);
    logic [1:0] ab;
    case (p)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       ab_q, ab_d;
  logic             z_q, z_d;
  logic             dir_q, dir_d;
  logic             step_pulse_q, step_pulse_d;
  logic             req_vld;
  logic             step_fire;

  // Next-state logic: prescaler, step decision, position, and phase update
  always_comb begin
    div_cnt_d    = div_cnt_q;
    pos_d        = pos_q;
    ab_d         = ab_q;
    z_d          = z_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;

    req_vld   = en & (horario ^ antihorario);
    // Use >= rather than == so that lowering period below the current count
    // fires on the next edge instead of waiting for div_cnt to wrap.
    step_fire = req_vld && (div_cnt_q >= period);

    if (!en) begin
      div_cnt_d = div_cnt_q;
    end else if (!req_vld) begin
      div_cnt_d = '0;
    end else if (step_fire) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (step_fire) begin
      dir_d = horario;
      if (horario) begin
        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
      end else begin
        pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
      end
      ab_d         = phase_of(pos_d[1:0]);
      z_d          = (pos_d == '0);
      step_pulse_d = 1'b1;
    end

`ifdef ENC_POS_LOAD_EN
    // An in-range load overrides any step on the same edge; an out-of-range load is dropped
    if (pos_load && ({1'b0, pos_value} < {1'b0, POS_MAX} + (POS_W+1)'(1))) begin
      pos_d        = pos_value;
      ab_d         = phase_of(pos_value[1:0]);
      z_d          = (pos_value == '0);
      div_cnt_d    = '0;
      step_pulse_d = 1'b0;
    end
`endif
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      pos_q        <= '0;
      ab_q         <= 2'b00;
      z_q          <= 1'b0;
      dir_q        <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pos_q        <= pos_d;
      ab_q         <= ab_d;
      z_q          <= z_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign A          = ab_q[1];
  assign B          = ab_q[0];
  assign Z          = z_q;
  assign position   = pos_q;
  assign dir        = dir_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen at CPR=400, with hand-computed expectations.
// Inputs are driven 1ns after each rising edge, and outputs are sampled at the same point.
// The position-load checks run only when ENC_POS_LOAD_EN is defined.
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        horario = 1'b0;
  logic        antihorario = 1'b0;
  logic [15:0] period = '0;
`ifdef ENC_POS_LOAD_EN
  logic        pos_load = 1'b0;
  logic [15:0] pos_value = '0;
`endif
  logic        A, B, Z, dir, step_pulse;
  logic [15:0] position;

  int vectors = 0;
  int errors  = 0;

  quad_encoder_gen #(.CPR(400), .DIV_W(16), .POS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .horario(horario), .antihorario(antihorario),
    .period(period),
`ifdef ENC_POS_LOAD_EN
    .pos_load(pos_load), .pos_value(pos_value),
`endif
    .A(A), .B(B), .Z(Z), .position(position), .dir(dir), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks {A,B}, position, Z and step_pulse together
  task automatic chk_st(input string tag, input logic [1:0] ab, input int pos,
                        input logic z, input logic sp);
    chk({tag, ".ab"},  {30'd0, A, B}, {30'd0, ab});
    chk({tag, ".pos"}, {16'd0, position}, pos);
    chk({tag, ".z"},   {31'd0, Z}, {31'd0, z});
    chk({tag, ".sp"},  {31'd0, step_pulse}, {31'd0, sp});
  endtask

  initial begin
    // Reset state
    #3;
    chk_st("rst0", 2'b00, 0, 1'b0, 1'b0);
    chk("rst0.dir", {31'd0, dir}, 0);
    tick(1);
    rst_n = 1'b1;
    en    = 1'b1;

    // period=0, horario: one step per clock
    period  = 16'd0;
    horario = 1'b1;
    tick(1); chk_st("cw1", 2'b10, 1, 1'b0, 1'b1); chk("cw1.dir", {31'd0, dir}, 1);
    tick(1); chk_st("cw2", 2'b11, 2, 1'b0, 1'b1);
    tick(1); chk_st("cw3", 2'b01, 3, 1'b0, 1'b1);
    tick(1); chk_st("cw4", 2'b00, 4, 1'b0, 1'b1);

    // Asynchronous reset takes effect with no clock edge
    horario = 1'b0;
    rst_n   = 1'b0;
    #2;
    chk_st("arst", 2'b00, 0, 1'b0, 1'b0);
    chk("arst.dir", {31'd0, dir}, 0);
    tick(1);
    rst_n = 1'b1;

    // period=3, antihorario: step on the 4th edge, then every 4th edge
    period      = 16'd3;
    antihorario = 1'b1;
    tick(1); chk_st("rate1", 2'b00, 0, 1'b0, 1'b0);
    tick(1); chk_st("rate2", 2'b00, 0, 1'b0, 1'b0);
    tick(1); chk_st("rate3", 2'b00, 0, 1'b0, 1'b0);
    tick(1); chk_st("rate4", 2'b01, 399, 1'b0, 1'b1); chk("rate4.dir", {31'd0, dir}, 0);
    tick(3); chk_st("rate7", 2'b01, 399, 1'b0, 1'b0);
    tick(1); chk_st("rate8", 2'b11, 398, 1'b0, 1'b1);

    // Wrap and index
    antihorario = 1'b0;
    horario     = 1'b1;
    period      = 16'd0;
    tick(1); chk_st("wrap399", 2'b01, 399, 1'b0, 1'b1);
    tick(1); chk_st("wrap0", 2'b00, 0, 1'b1, 1'b1); chk("wrap0.dir", {31'd0, dir}, 1);
    tick(1); chk_st("wrap1", 2'b10, 1, 1'b0, 1'b1);

    // Invalid request clears a partly counted prescaler
    period = 16'd2;
    tick(1); chk_st("pre", 2'b10, 1, 1'b0, 1'b0);   // div_cnt now 1
    antihorario = 1'b1;                              // both high
    for (int i = 0; i < 10; i++) begin
      tick(1); chk_st("both", 2'b10, 1, 1'b0, 1'b0);
    end
    horario = 1'b0; antihorario = 1'b0;
    tick(1); chk_st("none", 2'b10, 1, 1'b0, 1'b0);
    horario = 1'b1;
    tick(2); chk_st("clr2", 2'b10, 1, 1'b0, 1'b0);  // a stale div_cnt would step here
    tick(1); chk_st("clr3", 2'b11, 2, 1'b0, 1'b1);

    // Two cw steps from 1, then reverse and return to 1
    tick(3); chk_st("rev_cw", 2'b01, 3, 1'b0, 1'b1);
    horario = 1'b0; antihorario = 1'b1;
    tick(2); chk_st("rev_wait", 2'b01, 3, 1'b0, 1'b0);
    tick(1); chk_st("rev_ccw1", 2'b11, 2, 1'b0, 1'b1); chk("rev.dir", {31'd0, dir}, 0);
    tick(3); chk_st("rev_ccw2", 2'b10, 1, 1'b0, 1'b1);

    // en low for 5 cycles mid-count delays the step by exactly 5
    tick(1);                                          // div_cnt 1
    en = 1'b0;
    tick(5); chk_st("en_frz", 2'b10, 1, 1'b0, 1'b0);
    en = 1'b1;
    tick(1); chk_st("en_res1", 2'b10, 1, 1'b0, 1'b0);
    tick(1); chk_st("en_res2", 2'b00, 0, 1'b1, 1'b1);

    // Lowering period below the current count fires on the next edge
    antihorario = 1'b0; horario = 1'b1;
    period = 16'd5;
    tick(3); chk_st("lower_wait", 2'b00, 0, 1'b1, 1'b0);   // div_cnt 3
    period = 16'd1;
    tick(1); chk_st("lower_fire", 2'b10, 1, 1'b0, 1'b1);

`ifdef ENC_POS_LOAD_EN
    horario   = 1'b0;
    pos_load  = 1'b1;
    pos_value = 16'h0102;
    tick(1); chk_st("load258", 2'b11, 258, 1'b0, 1'b0);
    pos_value = 16'd400;
    tick(1); chk_st("load400", 2'b11, 258, 1'b0, 1'b0);
    period    = 16'd0;
    horario   = 1'b1;
    pos_value = 16'd5;
    tick(1); chk_st("load_step", 2'b10, 5, 1'b0, 1'b0);
    pos_load  = 1'b0;
    tick(1); chk_st("after_load", 2'b11, 6, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_gen.md
Name: quad_encoder_gen

Overview:
Parametrised quadrature encoder emulator. Generates A/B quadrature plus a once-per-revolution index Z at a programmable step rate, and tracks the shaft position modulo CPR. It is the next generation of the fixed one-step-per-clock encoder model. It drives decoder and motor-control blocks under test in the FPGA exercises.

Parameters:
CPR, 400, quadrature counts per revolution; must be a multiple of 4 and at least 4.
DIV_W, 16, width of the step-period prescaler.
POS_W, 16, width of the position output; must satisfy 2^POS_W >= CPR.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  step enable; when low, the prescaler and state hold
horario  in  1  clockwise request
antihorario  in  1  counter-clockwise request
period  in  DIV_W  step interval = period+1 clk cycles
A  out  1  quadrature channel A (registered)
B  out  1  quadrature channel B (registered)
Z  out  1  index; high while position==0 after a step (registered)
position  out  POS_W  current count, 0..CPR-1
dir  out  1  direction of last step: 1 = horario, 0 = antihorario
step_pulse  out  1  one-cycle strobe in the cycle A/B change

Behaviour:
- Reset, asynchronous, takes effect immediately: {A,B}=00, position=0, Z=0, dir=0, step_pulse=0, prescaler=0.
- Move request valid = en & (horario ^ antihorario). Both inputs high or both low means no request.
- Prescaler div_cnt:
  - No valid request: div_cnt clears to 0; outputs hold.
  - Valid request and div_cnt==period: step occurs this edge; div_cnt becomes 0.
  - Valid request otherwise: div_cnt increments.
  - period=0: one step per clock while the request is valid.
  - First step occurs period+1 cycles after the request becomes valid.
- period is sampled every cycle. If a lowered period is already <= div_cnt, the step fires on the next edge (compare is >=, not ==).
- Step, horario: {A,B} 00->10->11->01->00; position +1, wraps CPR-1 -> 0; dir=1.
- Step, antihorario: reverse sequence; position -1, wraps 0 -> CPR-1; dir=0.
- Quadrature phase always equals position mod 4: 0->00, 1->10, 2->11, 3->01. This holds across wrap because CPR%4==0.
- step_pulse=1 for exactly the cycle following a step edge, aligned with the new A/B. Otherwise 0.
- Z is registered with the step: Z <= (new position == 0). Z stays at 0 after reset until a step lands on 0.
- Direction reversal between steps: no dead cycle. The next step uses the new direction with the normal period timing; div_cnt is not cleared on reversal.
- en low mid-count: div_cnt freezes (not cleared). Counting resumes when en returns high.
- Illegal {A,B} state cannot occur; no recovery logic needed.

Optional Feature:
Macro ENC_POS_LOAD_EN.
- With the macro defined: adds ports pos_load (in, 1) and pos_value (in, POS_W).
- On the clock edge where pos_load=1 and pos_value<CPR:
  - position <= pos_value; {A,B} set from pos_value mod 4 using the mapping above.
  - Z <= (pos_value==0); div_cnt <= 0; step_pulse=0.
  - Load has priority over a simultaneous step.
- pos_load with pos_value>=CPR is ignored entirely.
- Without the macro: no extra ports; position changes only by steps.

Test Plan:
- Reset check: CPR=400, period=0, horario=1 held for 4 cycles -> {A,B}: 10,11,01,00; position 1,2,3,4; step_pulse high all 4 cycles; dir=1.
- Rate: period=3, antihorario=1 from position 0 -> first step after 4 cycles; position=399, {A,B}=01, Z=0; step_pulse every 4th cycle.
- Wrap/index: from position 398, horario, period=0 -> 399 then 0 with Z=1; next step gives 1 with Z=0.
- Invalid request: horario=antihorario=1 for 10 cycles, then both 0 -> no step_pulse; A, B and position unchanged; div_cnt cleared.
- Reversal and en: period=2; horario for 2 steps, then antihorario -> position returns to its start value with no skipped phase. en=0 mid-count for 5 cycles -> step delayed by exactly 5 cycles.
- ENC_POS_LOAD_EN: load 0x0102 (258) -> position=258, {A,B}=11. Load 400 -> ignored. Load coincident with a step -> the loaded value wins.
